// File: rtl/serial_word_rx_if.sv
// Serial receive link and parallel word handshake for serial_word_rx.
// The slave modport is the receiver; master is the transmitter/consumer side.
interface serial_word_rx_if #(
   parameter int WIDTH = 4
);
   logic             ser_in;
   logic             ser_valid;
   logic             dir;
   logic             frame_start;
   logic             P_ready;
   logic             clr_overrun;
   logic [WIDTH-1:0] P_out;
   logic             P_valid;
   logic             busy;
   logic             overrun;

   modport slave (
      input  ser_in, ser_valid, dir, frame_start, P_ready, clr_overrun,
      output P_out, P_valid, busy, overrun
   );

   modport master (
      output ser_in, ser_valid, dir, frame_start, P_ready, clr_overrun,
      input  P_out, P_valid, busy, overrun
   );
endinterface

// File: rtl/serial_word_rx.sv
// Reassembles WIDTH-bit words from an LSB- or MSB-first serial stream into a one-entry output buffer.
// Word is visible the edge its last bit is sampled; a completion that finds the buffer full is dropped and flagged.
module serial_word_rx #(
   parameter int WIDTH = 4
) (
   input  logic CLK,
   input  logic Clear,
   serial_word_rx_if.slave bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic {IDLE, RECV} state_t;

   state_t           state;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] p_out_q;
   logic [CW-1:0]    cnt;
   logic             dir_q;
   logic             dir_use;
   logic             first;
   logic             complete;
   logic             take;
   logic             p_valid_q;
   logic             overrun_q;

   always_comb begin
      // frame_start restarts the word, so this bit is treated as bit 0
      first    = bus.frame_start || (state == IDLE);
      dir_use  = first ? bus.dir : dir_q;
      shifted  = dir_use ? {sr[WIDTH-2:0], bus.ser_in} : {bus.ser_in, sr[WIDTH-1:1]};
      complete = bus.ser_valid && !first && (cnt == CW'(WIDTH - 1));
      take     = !p_valid_q || bus.P_ready;
   end

   always_ff @(posedge CLK or posedge Clear) begin
      if (Clear) begin
         state     <= IDLE;
         sr        <= '0;
         cnt       <= '0;
         dir_q     <= 1'b0;
         p_out_q   <= '0;
         p_valid_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (bus.ser_valid) begin
            sr <= shifted;
            if (first) begin
               dir_q <= bus.dir;
            end
            if (complete) begin
               cnt   <= '0;
               state <= IDLE;
            end else if (first) begin
               cnt   <= CW'(1);
               state <= RECV;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else if (bus.frame_start) begin
            cnt   <= '0;
            state <= IDLE;
         end

         if (complete && take) begin
            p_out_q   <= shifted;
            p_valid_q <= 1'b1;
         end else if (p_valid_q && bus.P_ready) begin
            p_valid_q <= 1'b0;
         end

         // a drop in the same cycle as clr_overrun keeps the flag set
         if (complete && !take) begin
            overrun_q <= 1'b1;
         end else if (bus.clr_overrun) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign bus.P_out   = p_out_q;
   assign bus.P_valid = p_valid_q;
   assign bus.overrun = overrun_q;
   assign bus.busy    = (cnt != '0);
endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx at WIDTH=4: framing, both bit orders, overrun, streaming, resync, async clear.
module tb_serial_word_rx;
   logic CLK;
   logic Clear;
   int   tests;
   int   fails;

   serial_word_rx_if #(.WIDTH(4)) bus ();

   serial_word_rx #(.WIDTH(4)) dut (
      .CLK   (CLK),
      .Clear (Clear),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic b);
      bus.ser_in    = b;
      bus.ser_valid = 1'b1;
      @(posedge CLK);
      #1;
      bus.ser_valid = 1'b0;
      bus.ser_in    = 1'b0;
   endtask

   task automatic send4(input logic b0, input logic b1, input logic b2, input logic b3);
      send(b0);
      send(b1);
      send(b2);
      send(b3);
   endtask

   task automatic consume();
      bus.P_ready = 1'b1;
      @(posedge CLK);
      #1;
      bus.P_ready = 1'b0;
   endtask

   logic [3:0] words [3];
   logic [3:0] prev;

   initial begin
      tests = 0;
      fails = 0;
      words[0] = 4'b0011;
      words[1] = 4'b1100;
      words[2] = 4'b0101;
      bus.ser_in      = 1'b0;
      bus.ser_valid   = 1'b0;
      bus.dir         = 1'b0;
      bus.frame_start = 1'b0;
      bus.P_ready     = 1'b0;
      bus.clr_overrun = 1'b0;
      Clear = 1'b1;
      #1;
      check("rst_pout",    32'(bus.P_out),   32'h0);
      check("rst_pvalid",  32'(bus.P_valid), 32'h0);
      check("rst_busy",    32'(bus.busy),    32'h0);
      check("rst_overrun", 32'(bus.overrun), 32'h0);
      @(posedge CLK);
      #1;
      Clear = 1'b0;
      @(posedge CLK);
      #1;

      // LSB-first 0,1,0,1 -> 1010
      bus.dir = 1'b0;
      send(0);
      check("lsb_busy_mid", 32'(bus.busy), 32'h1);
      send(1); send(0); send(1);
      check("lsb_pout",   32'(bus.P_out),   32'hA);
      check("lsb_pvalid", 32'(bus.P_valid), 32'h1);
      check("lsb_busy",   32'(bus.busy),    32'h0);
      consume();
      check("consume_pvalid", 32'(bus.P_valid), 32'h0);
      check("consume_pout",   32'(bus.P_out),   32'hA);

      // gap of 3 idle cycles between bits 2 and 3
      send(0); send(1);
      repeat (3) @(posedge CLK);
      #1;
      check("gap_busy",   32'(bus.busy),    32'h1);
      check("gap_pvalid", 32'(bus.P_valid), 32'h0);
      send(0); send(1);
      check("gap_pout",   32'(bus.P_out),   32'hA);
      check("gap_pvalid2", 32'(bus.P_valid), 32'h1);
      consume();

      // MSB-first
      bus.dir = 1'b1;
      send4(1, 1, 0, 0);
      check("msb_pout_c", 32'(bus.P_out),   32'hC);
      check("msb_pvalid", 32'(bus.P_valid), 32'h1);
      consume();
      send4(1, 0, 1, 0);
      check("msb_pout_a", 32'(bus.P_out), 32'hA);
      consume();
      // dir flips after bit 1 and must be ignored
      bus.dir = 1'b1;
      send(1);
      bus.dir = 1'b0;
      send(1); send(0); send(0);
      check("msb_dirtoggle", 32'(bus.P_out),   32'hC);
      check("msb_dt_valid",  32'(bus.P_valid), 32'h1);
      consume();

      // overrun: second word dropped while first is held
      bus.dir = 1'b0;
      send4(0, 1, 0, 1);
      check("ovr_first", 32'(bus.P_out), 32'hA);
      send4(0, 1, 1, 0);
      check("ovr_pout",    32'(bus.P_out),   32'hA);
      check("ovr_pvalid",  32'(bus.P_valid), 32'h1);
      check("ovr_overrun", 32'(bus.overrun), 32'h1);
      // drop coincident with clr_overrun: set wins
      send(1); send(1); send(1);
      bus.clr_overrun = 1'b1;
      send(1);
      bus.clr_overrun = 1'b0;
      check("ovr_setwins", 32'(bus.overrun), 32'h1);
      check("ovr_pout2",   32'(bus.P_out),   32'hA);
      consume();
      check("ovr_consumed", 32'(bus.P_valid), 32'h0);
      check("ovr_sticky",   32'(bus.overrun), 32'h1);
      bus.clr_overrun = 1'b1;
      @(posedge CLK);
      #1;
      bus.clr_overrun = 1'b0;
      check("ovr_cleared", 32'(bus.overrun), 32'h0);

      // streaming: ready only on completion cycles exercises consume+load
      prev = 4'hA;
      for (int w = 0; w < 3; w++) begin
         for (int i = 0; i < 4; i++) begin
            bus.ser_in    = words[w][i];
            bus.ser_valid = 1'b1;
            bus.P_ready   = (i == 3);
            @(posedge CLK);
            #1;
            if (i < 3) begin
               check("strm_hold_valid", 32'(bus.P_valid), (w > 0) ? 32'h1 : 32'h0);
               check("strm_hold_pout",  32'(bus.P_out),   32'(prev));
            end
         end
         check("strm_pout",    32'(bus.P_out),   32'(words[w]));
         check("strm_pvalid",  32'(bus.P_valid), 32'h1);
         check("strm_overrun", 32'(bus.overrun), 32'h0);
         prev = words[w];
      end
      bus.ser_valid = 1'b0;
      bus.P_ready   = 1'b0;
      consume();

      // resync discards the leading 1,1
      send(1); send(1);
      bus.frame_start = 1'b1;
      send(0);
      bus.frame_start = 1'b0;
      check("sync_busy", 32'(bus.busy), 32'h1);
      send(1); send(0);
      check("sync_notyet", 32'(bus.P_valid), 32'h0);
      send(1);
      check("sync_pout",    32'(bus.P_out),   32'hA);
      check("sync_pvalid",  32'(bus.P_valid), 32'h1);
      check("sync_overrun", 32'(bus.overrun), 32'h0);

      // frame_start alone abandons the partial word
      send(1);
      bus.frame_start = 1'b1;
      @(posedge CLK);
      #1;
      bus.frame_start = 1'b0;
      check("fs_busy", 32'(bus.busy), 32'h0);

      // async Clear mid-word with buffer full and overrun set
      send4(0, 0, 0, 0);
      check("pre_clr_overrun", 32'(bus.overrun), 32'h1);
      send(1); send(1);
      #2;
      Clear = 1'b1;
      #1;
      check("clr_pout",    32'(bus.P_out),   32'h0);
      check("clr_pvalid",  32'(bus.P_valid), 32'h0);
      check("clr_busy",    32'(bus.busy),    32'h0);
      check("clr_overrun", 32'(bus.overrun), 32'h0);
      Clear = 1'b0;
      send4(1, 0, 0, 1);
      check("post_clr_pout",   32'(bus.P_out),   32'h9);
      check("post_clr_pvalid", 32'(bus.P_valid), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
